argmax_seq: RTL and testbench
=============================

Name: argmax_seq

Overview:
- Final classification stage of the network.
- Sits directly downstream of the output-layer pass-through register.
- Accepts the flat vector of output-layer neuron values with a one-cycle valid, and scans it serially with one signed comparison per cycle.
- Emits the index and value of the largest element as a one-cycle-valid result for the host/AXI readout.

Parameters:
- NUM_INPUT, 10, number of output-layer elements to compare (legal range 2..2**IDX_WIDTH).
- INPUT_WIDTH, 16, width of each element; two's-complement fixed point (matches `dataWidth`).
- IDX_WIDTH, 4, width of the result index; must be >= clog2(NUM_INPUT).

Ports:
- i_clk  input  1  single clock, all state updates on rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_data  input  NUM_INPUT*INPUT_WIDTH  packed elements; element k occupies bits [(k+1)*INPUT_WIDTH-1 : k*INPUT_WIDTH].
- i_valid  input  1  one-cycle strobe; i_data is valid in the same cycle.
- o_ready  output  1  high when the block will accept i_valid this cycle.
- o_max_idx  output  IDX_WIDTH  index of the maximum element.
- o_max_val  output  INPUT_WIDTH  value of the maximum element.
- o_valid  output  1  one-cycle pulse; o_max_idx and o_max_val are valid in that cycle.

Behaviour:
- Reset: asynchronous and active-low, as fixed above.
  - While i_rst_n=0: state=IDLE, buffer/counter/running max/running idx = 0, o_max_idx=0, o_max_val=0, o_valid=0.
  - o_ready=1 as soon as reset is released.
- FSM has two states: IDLE and SCAN. o_ready = (state==IDLE), decoded from the registered state.
- IDLE, with i_valid=1:
  - Capture all of i_data into the internal buffer.
  - Running max <= element 0; running idx <= 0; counter <= 1.
  - Go to SCAN.
- IDLE, with i_valid=0: hold all state.
- SCAN, each cycle:
  - Compare buffer element[counter] against running max as signed INPUT_WIDTH values.
  - Strictly greater: replace running max and idx. Equal: keep existing, so ties resolve to the lowest index.
  - counter increments by 1.
- SCAN, at counter==NUM_INPUT-1:
  - Register the final comparison result, computed combinationally including the last element, into o_max_val and o_max_idx.
  - Set o_valid <= 1 and return to IDLE.
- Latency and throughput:
  - i_valid sampled at edge T → o_valid high in the cycle following edge T+NUM_INPUT-1 (default: 9 edges).
  - o_ready is 1 during the o_valid cycle, so back-to-back vectors are accepted every NUM_INPUT cycles.
- o_valid is a single-cycle pulse, deasserted at the next edge.
- o_max_idx and o_max_val hold their last result until the next result overwrites them.
- i_valid while o_ready=0: ignored and dropped. The buffer is not modified and the scan in progress is unaffected. No error flag.
- i_data changing during SCAN has no effect, because the block operates on the captured buffer only.
- Reset asserted mid-SCAN: scan aborts, no o_valid is produced, outputs return to 0.
- Arithmetic: comparison only, no extension or saturation. Extremes 0x8000 and 0x7FFF must compare correctly as signed values.

Decomposition:
- Shared include/package entries:
  - the `numNeuronLayer` final-layer count and `dataWidth` defines used to set NUM_INPUT and INPUT_WIDTH at instantiation;
  - FSM state encodings (IDLE=1'b0, SCAN=1'b1).
- No sub-module needed. The element mux plus signed comparator is inline logic.
- Optional: factor the signed comparator as cmp_signed_gt if reused by later stages.

Test Plan:
- Defaults, i_data elements = {3,1,4,1,5,9,2,6,5,3} (element 0 first), one i_valid pulse → o_valid exactly 9 cycles later; o_max_idx=5, o_max_val=9; o_valid low the next cycle.
- Signed values: elements all 0xFFF0 (-16) except element 7 = 0xFFFF (-1) and element 2 = 0x8000 → idx=7, val=0xFFFF. Then a vector with element 9 = 0x7FFF, others 0 → idx=9, val=0x7FFF.
- Ties: elements {5,8,8,0,8,0,0,0,0,0} → idx=1, val=8.
- Busy handling: i_valid at T with max at idx 2; second i_valid at T+3 carrying max at idx 8 → only one o_valid, with idx=2. A third i_valid in the o_valid cycle is accepted, giving its own result 9 cycles later.
- Reset mid-scan: i_valid, then i_rst_n=0 at T+4 for 2 cycles → no o_valid ever; outputs read 0; o_ready=1 after release. A subsequent valid vector is processed normally.
- Back-to-back streaming: 20 random vectors, each issued in the cycle o_ready returns, checked against a reference argmax with lowest-index tie-break → all 20 results match, with exactly one o_valid per vector.

Source files
------------

// File: rtl/argmax_seq_pkg.sv
// Shared constants and FSM encoding for the argmax classifier stage.
// Layer sizes come from here so the top can be sized at instantiation.
package argmax_seq_pkg;

  // Final-layer neuron count and fixed-point data width
  localparam int NUM_NEURON_LAYER = 10;
  localparam int DATA_WIDTH       = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/argmax_seq.sv
// Serial argmax: captures a packed vector, one signed compare per cycle.
// Ports: i_clk, i_rst_n, i_data/i_valid in; o_ready, o_max_idx/val, o_valid out.
module argmax_seq
  import argmax_seq_pkg::*;
#(
  parameter int NUM_INPUT   = NUM_NEURON_LAYER,
  parameter int INPUT_WIDTH = DATA_WIDTH,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_INPUT*INPUT_WIDTH-1:0] i_data,
  input  logic                           i_valid,
  output logic                           o_ready,
  output logic [IDX_WIDTH-1:0]           o_max_idx,
  output logic [INPUT_WIDTH-1:0]         o_max_val,
  output logic                           o_valid
);

  localparam logic [IDX_WIDTH-1:0] LAST =
    IDX_WIDTH'(NUM_INPUT - 1);

  state_e r_state;
  state_e w_state_nxt;

  logic [INPUT_WIDTH-1:0] r_buf [NUM_INPUT];
  logic [IDX_WIDTH-1:0]   r_cnt;
  logic [INPUT_WIDTH-1:0] r_max;
  logic [IDX_WIDTH-1:0]   r_idx;
  logic [IDX_WIDTH-1:0]   r_o_idx;
  logic [INPUT_WIDTH-1:0] r_o_val;
  logic                   r_o_valid;

  logic [INPUT_WIDTH-1:0] w_elem;
  logic                   w_gt;
  logic                   w_last;
  logic [INPUT_WIDTH-1:0] w_new_max;
  logic [IDX_WIDTH-1:0]   w_new_idx;

  // Strict greater-than keeps the earlier index on ties
  assign w_elem    = r_buf[r_cnt];
  assign w_gt      = $signed(w_elem) > $signed(r_max);
  assign w_last    = (r_cnt == LAST);
  assign w_new_max = w_gt ? w_elem : r_max;
  assign w_new_idx = w_gt ? r_cnt : r_idx;

  assign o_ready   = (r_state == IDLE);
  assign o_max_idx = r_o_idx;
  assign o_max_val = r_o_val;
  assign o_valid   = r_o_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (i_valid) w_state_nxt = SCAN;
      SCAN: if (w_last)  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_INPUT; k++)
        r_buf[k] <= '0;
      r_cnt     <= '0;
      r_max     <= '0;
      r_idx     <= '0;
      r_o_idx   <= '0;
      r_o_val   <= '0;
      r_o_valid <= 1'b0;
    end else begin
      r_o_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_valid) begin
            for (int k = 0; k < NUM_INPUT; k++)
              r_buf[k] <=
                i_data[k*INPUT_WIDTH +: INPUT_WIDTH];
            r_max <= i_data[INPUT_WIDTH-1:0];
            r_idx <= '0;
            r_cnt <= IDX_WIDTH'(1);
          end
        end
        SCAN: begin
          r_max <= w_new_max;
          r_idx <= w_new_idx;
          r_cnt <= r_cnt + IDX_WIDTH'(1);
          if (w_last) begin
            r_o_val   <= w_new_max;
            r_o_idx   <= w_new_idx;
            r_o_valid <= 1'b1;
            r_cnt     <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_seq.sv
// Directed bench for argmax_seq: latency, signed/tie ordering,
// busy drop, mid-scan reset and back-to-back streaming.
module tb_argmax_seq;

  localparam int NI = 10;
  localparam int W  = 16;
  localparam int IW = 4;

  logic            clk;
  logic            rst_n;
  logic [NI*W-1:0] data;
  logic            vin;
  logic            rdy;
  logic [IW-1:0]   midx;
  logic [W-1:0]    mval;
  logic            vout;

  int n_tests;
  int n_fail;

  logic [W-1:0]    el [NI];
  logic [NI*W-1:0] vecs [20];
  logic [IW-1:0]   e_idx [20];
  logic [W-1:0]    e_val [20];

  argmax_seq #(
    .NUM_INPUT  (NI),
    .INPUT_WIDTH(W),
    .IDX_WIDTH  (IW)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_data   (data),
    .i_valid  (vin),
    .o_ready  (rdy),
    .o_max_idx(midx),
    .o_max_val(mval),
    .o_valid  (vout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NI*W-1:0] pack_el();
    logic [NI*W-1:0] v;
    v = '0;
    for (int k = 0; k < NI; k++)
      v[k*W +: W] = el[k];
    return v;
  endfunction

  task automatic ref_max(output logic [IW-1:0] bi,
                         output logic [W-1:0] bv);
    bi = '0;
    bv = el[0];
    for (int k = 1; k < NI; k++)
      if ($signed(el[k]) > $signed(bv)) begin
        bv = el[k];
        bi = IW'(k);
      end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Drive one-cycle strobe; returns at the negedge after it is sampled
  task automatic pulse(input logic [NI*W-1:0] v);
    @(negedge clk);
    data = v;
    vin  = 1'b1;
    @(negedge clk);
    vin  = 1'b0;
  endtask

  // Negedges until o_valid seen; -1 if the bound expires
  task automatic wait_valid(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (vout) begin
        cyc = k;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    int seen;
    logic [IW-1:0] bi;
    logic [W-1:0]  bv;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    vin     = 1'b0;
    data    = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(rdy), 32'd1);
    chk("rst_valid", 32'(vout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(rdy), 32'd1);
    chk("rel_idx", 32'(midx), 32'd0);
    chk("rel_val", 32'(mval), 32'd0);

    // Basic vector, latency 9
    el = '{16'd3, 16'd1, 16'd4, 16'd1, 16'd5,
           16'd9, 16'd2, 16'd6, 16'd5, 16'd3};
    pulse(pack_el());
    chk("busy_ready", 32'(rdy), 32'd0);
    wait_valid(cyc);
    chk("pi_lat", 32'(cyc), 32'd9);
    chk("pi_idx", 32'(midx), 32'd5);
    chk("pi_val", 32'(mval), 32'd9);
    chk("pi_ready", 32'(rdy), 32'd1);
    @(negedge clk);
    chk("pi_pulse", 32'(vout), 32'd0);
    chk("pi_hold", 32'(mval), 32'd9);

    // Negative values and extremes
    for (int k = 0; k < NI; k++) el[k] = 16'hFFF0;
    el[7] = 16'hFFFF;
    el[2] = 16'h8000;
    pulse(pack_el());
    wait_valid(cyc);
    chk("neg_lat", 32'(cyc), 32'd9);
    chk("neg_idx", 32'(midx), 32'd7);
    chk("neg_val", 32'(mval), 32'hFFFF);

    for (int k = 0; k < NI; k++) el[k] = 16'h0000;
    el[9] = 16'h7FFF;
    pulse(pack_el());
    wait_valid(cyc);
    chk("pmax_idx", 32'(midx), 32'd9);
    chk("pmax_val", 32'(mval), 32'h7FFF);

    // Ties resolve to lowest index
    el = '{16'd5, 16'd8, 16'd8, 16'd0, 16'd8,
           16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    pulse(pack_el());
    wait_valid(cyc);
    chk("tie_idx", 32'(midx), 32'd1);
    chk("tie_val", 32'(mval), 32'd8);

    // Busy: second strobe at T+3 is dropped
    el = '{16'd1, 16'd2, 16'd50, 16'd3, 16'd0,
           16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    pulse(pack_el());
    repeat (2) @(negedge clk);
    el[8] = 16'd100;
    data = pack_el();
    vin  = 1'b1;
    @(negedge clk);
    vin  = 1'b0;
    for (int k = 0; k < NI; k++) el[k] = 16'hFFFB;
    el[4] = 16'hFFFE;
    data = pack_el();
    wait_valid(cyc);
    chk("busy_lat", 32'(cyc), 32'd6);
    chk("busy_idx", 32'(midx), 32'd2);
    chk("busy_val", 32'(mval), 32'd50);
    // Third strobe in the o_valid cycle is accepted
    vin = 1'b1;
    @(negedge clk);
    vin = 1'b0;
    chk("third_pulse", 32'(vout), 32'd0);
    wait_valid(cyc);
    chk("third_lat", 32'(cyc), 32'd9);
    chk("third_idx", 32'(midx), 32'd4);
    chk("third_val", 32'(mval), 32'hFFFE);

    // Reset during scan
    el = '{16'd1, 16'd2, 16'd3, 16'd77, 16'd4,
           16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
    pulse(pack_el());
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_idx", 32'(midx), 32'd0);
    chk("mrst_val", 32'(mval), 32'd0);
    chk("mrst_valid", 32'(vout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mrst_ready", 32'(rdy), 32'd1);
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (vout) seen++;
    end
    chk("mrst_none", 32'(seen), 32'd0);
    chk("mrst_idx2", 32'(midx), 32'd0);
    pulse(pack_el());
    wait_valid(cyc);
    chk("post_lat", 32'(cyc), 32'd9);
    chk("post_idx", 32'(midx), 32'd3);
    chk("post_val", 32'(mval), 32'd77);

    // Back-to-back random stream
    for (int v = 0; v < 20; v++) begin
      for (int k = 0; k < NI; k++) begin
        if (v % 2 == 1)
          el[k] = 16'($urandom_range(0, 6)) - 16'd3;
        else
          el[k] = 16'($urandom);
      end
      vecs[v] = pack_el();
      ref_max(bi, bv);
      e_idx[v] = bi;
      e_val[v] = bv;
    end
    pulse(vecs[0]);
    for (int v = 0; v < 20; v++) begin
      wait_valid(cyc);
      chk($sformatf("str%0d_lat", v), 32'(cyc), 32'd9);
      chk($sformatf("str%0d_idx", v),
          32'(midx), 32'(e_idx[v]));
      chk($sformatf("str%0d_val", v),
          32'(mval), 32'(e_val[v]));
      if (v < 19) begin
        data = vecs[v+1];
        vin  = 1'b1;
        @(negedge clk);
        vin  = 1'b0;
      end
    end
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (vout) seen++;
    end
    chk("str_tail", 32'(seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
